// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver and keypad decoder.
//   - Scan-code constants for the keys the game listens to, plus the
//     extended (E0) and break (F0) prefixes.
//   - Frame receiver state enum.
//   - Action index constants and a key-to-action lookup that returns a
//     one-hot action mask (all zero for an unmapped key).
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_LEFT  = 8'h6B;  // extended
    localparam logic [7:0] SC_RIGHT = 8'h74;  // extended
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_SPACE = 8'h29;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    localparam int NUM_ACT   = 5;
    localparam int ACT_LEFT  = 0;
    localparam int ACT_RIGHT = 1;
    localparam int ACT_START = 2;
    localparam int ACT_RESET = 3;
    localparam int ACT_SEL   = 4;

    // One-hot action for key (ext, code); zero when the key is unmapped.
    function automatic logic [NUM_ACT-1:0] key_action(input logic ext,
                                                      input logic [7:0] code);
        logic [NUM_ACT-1:0] m;
        m = '0;
        if (!ext) begin
            case (code)
                SC_A:     m[ACT_LEFT]  = 1'b1;
                SC_D:     m[ACT_RIGHT] = 1'b1;
                SC_ENTER: m[ACT_START] = 1'b1;
                SC_ESC:   m[ACT_RESET] = 1'b1;
                SC_SPACE: m[ACT_SEL]   = 1'b1;
                default:  m = '0;
            endcase
        end else begin
            case (code)
                SC_LEFT:  m[ACT_LEFT]  = 1'b1;
                SC_RIGHT: m[ACT_RIGHT] = 1'b1;
                default:  m = '0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 host-side frame receiver.
// Synchronizes the raw PS/2 clock and data, filters the clock, and
// assembles 11-bit frames (start, 8 data LSB first, odd parity, stop).
// Ports:
//   clk, reset      system clock, asynchronous active-low reset
//   ps2_clk         raw PS/2 clock (asynchronous)
//   ps2_data        raw PS/2 data (asynchronous)
//   scan_valid      one-cycle strobe for a frame with good parity/stop
//   scan_code       last good byte, held until the next good frame
//   frame_err       one-cycle pulse on bad start/parity/stop or timeout
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       scan_valid,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_filt;
    logic          clk_filt_d;
    logic [FW-1:0] flt_cnt;
    logic          fall;
    logic          dat;

    frame_state_t  state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic          par_bit, par_n;
    logic [7:0]    code_n;
    logic          valid_n, err_n;
    logic [TW-1:0] to_cnt;
    logic          timeout;

    // Both lines reset to the idle-high level so no false fall after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
        end
    end

    // The filtered level follows the synced clock only after FILTER_LEN
    // consecutive samples that disagree with it; any agreeing sample restarts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            flt_cnt    <= '0;
        end else begin
            clk_filt_d <= clk_filt;
            if (clk_sync[1] == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_LAST) begin
                clk_filt <= clk_sync[1];
                flt_cnt  <= '0;
            end else begin
                flt_cnt <= flt_cnt + FW'(1);
            end
        end
    end

    assign fall = clk_filt_d & ~clk_filt;
    assign dat  = dat_sync[1];

    // Idle time since the last fall while a frame is open.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (fall || state == ST_IDLE) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    assign timeout = (state != ST_IDLE) && !fall && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            scan_code  <= '0;
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            par_bit    <= par_n;
            scan_code  <= code_n;
            scan_valid <= valid_n;
            frame_err  <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        par_n     = par_bit;
        code_n    = scan_code;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        if (timeout) begin
            // Partial byte is simply abandoned; the next start bit reloads it.
            state_n = ST_IDLE;
            err_n   = 1'b1;
        end else if (fall) begin
            case (state)
                ST_IDLE: begin
                    if (!dat) begin
                        state_n   = ST_DATA;
                        bit_cnt_n = '0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_n   = {dat, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = ST_PARITY;
                end
                ST_PARITY: begin
                    par_n   = dat;
                    state_n = ST_STOP;
                end
                ST_STOP: begin
                    // Odd parity: data plus parity bit must hold an odd count of ones.
                    if (dat && (^{par_bit, shift})) begin
                        valid_n = 1'b1;
                        code_n  = shift;
                    end else begin
                        err_n = 1'b1;
                    end
                    state_n = ST_IDLE;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keypad.sv
// PS/2 keyboard to game-button decoder.
// Receives scan codes through ps2_rx and turns key makes into single-cycle
// action pulses, suppressing typematic repeats with a held flag per action.
// Ports:
//   clk, reset      system clock, asynchronous active-low reset
//   ps2_clk         raw PS/2 clock (asynchronous)
//   ps2_data        raw PS/2 data (asynchronous)
//   left_pulse      Left-arrow or A make
//   right_pulse     Right-arrow or D make
//   start_pulse     Enter make
//   reset_pulse     Esc make
//   sel_level       toggles on each fired Space make
//   scan_valid      one-cycle strobe for each good frame
//   scan_code       last good byte
//   frame_err       one-cycle pulse on any frame error or timeout
module ps2_keypad
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       left_pulse,
    output logic       right_pulse,
    output logic       start_pulse,
    output logic       reset_pulse,
    output logic       sel_level,
    output logic       scan_valid,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    logic               ext, ext_n;
    logic               brk, brk_n;
    logic [NUM_ACT-1:0] held, held_n;
    logic [NUM_ACT-1:0] fire_n;
    logic [NUM_ACT-1:0] key;

    ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .scan_valid(scan_valid),
        .scan_code (scan_code),
        .frame_err (frame_err)
    );

    // scan_code already holds the new byte in the cycle scan_valid is high.
    always_comb begin
        ext_n  = ext;
        brk_n  = brk;
        held_n = held;
        fire_n = '0;
        key    = key_action(ext, scan_code);
        if (scan_valid) begin
            if (scan_code == SC_EXT) begin
                ext_n = 1'b1;
            end else if (scan_code == SC_BRK) begin
                brk_n = 1'b1;
            end else begin
                if (brk) begin
                    held_n = held & ~key;
                end else begin
                    // Repeats of a held key fire nothing.
                    fire_n = key & ~held;
                    held_n = held | key;
                end
                ext_n = 1'b0;
                brk_n = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ext         <= 1'b0;
            brk         <= 1'b0;
            held        <= '0;
            left_pulse  <= 1'b0;
            right_pulse <= 1'b0;
            start_pulse <= 1'b0;
            reset_pulse <= 1'b0;
            sel_level   <= 1'b0;
        end else begin
            ext         <= ext_n;
            brk         <= brk_n;
            held        <= held_n;
            left_pulse  <= fire_n[ACT_LEFT];
            right_pulse <= fire_n[ACT_RIGHT];
            start_pulse <= fire_n[ACT_START];
            reset_pulse <= fire_n[ACT_RESET];
            sel_level   <= sel_level ^ fire_n[ACT_SEL];
        end
    end

endmodule

// File: doc/ps2_keypad.md
Name: ps2_keypad

Overview:
- Receives PS/2 keyboard frames (the keyboard is the transmitter; this block is the host-side receiver).
- Decodes scan codes into the game's button-level controls: left, right, start, reset request, and the sel level.
- Sits beside the debouncers at the top level, so a keyboard can drive the same connectfour inputs as the board buttons and switch.
- Decoded pulses are clean single-cycle events; they need no further debouncing.

Parameters:
FILTER_LEN, 8, consecutive equal samples required before the filtered ps2_clk changes level
TIMEOUT_CYC, 200000, idle clk cycles mid-frame (2 ms at 100 MHz) before the frame is abandoned

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-low reset
ps2_clk  in  1  raw PS/2 clock from the keyboard (asynchronous)
ps2_data  in  1  raw PS/2 data from the keyboard (asynchronous)
left_pulse  out  1  one-cycle pulse on a Left-arrow or A make
right_pulse  out  1  one-cycle pulse on a Right-arrow or D make
start_pulse  out  1  one-cycle pulse on an Enter make
reset_pulse  out  1  one-cycle pulse on an Esc make
sel_level  out  1  level output; toggles on each Space make
scan_valid  out  1  one-cycle strobe when a frame is received with good parity
scan_code  out  8  last good byte; held until the next good frame
frame_err  out  1  one-cycle pulse on parity error, bad start/stop bit, or timeout

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; scan_code=0x00; frame FSM in IDLE; ext, brk and held flags cleared; filtered clock = 1.
- Input conditioning: ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - The synced clock goes through a saturating filter: the filtered level changes only after FILTER_LEN consecutive equal samples.
  - A falling edge of the filtered clock yields a one-cycle `fall` strobe.
  - Data is sampled on `fall`.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0 -> DATA, bit counter=0. On fall with data=1 -> pulse frame_err, stay in IDLE.
  - DATA: shift data in LSB first. After the 8th bit -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: on fall, the frame is good if stop=1 and the 9 bits (8 data + parity) have odd total parity.
    - Good frame: scan_code<=byte and scan_valid=1 on the next clk edge.
    - Otherwise: frame_err=1 on the next clk edge.
    - Either way -> IDLE.
- Timeout: a counter clears on every fall and counts while not in IDLE. At TIMEOUT_CYC -> frame_err pulse, return to IDLE, discard the partial byte.
- Decoder: acts in the cycle scan_valid is asserted; action pulses appear exactly 1 cycle after scan_valid.
  - 0xE0: set ext. 0xF0: set brk. No action for either.
  - Any other byte forms key=(ext,byte), then clears ext and brk.
  - Key map:
    - (0,1C) A and (1,6B) Left -> left
    - (0,23) D and (1,74) Right -> right
    - (0,5A) Enter -> start
    - (0,76) Esc -> reset
    - (0,29) Space -> sel
  - Unmapped keys: no action.
- Typematic suppression: each of the 5 actions has a held flag.
  - A make with held=0 fires the action and sets held.
  - A make with held=1 (repeat) does nothing.
  - A break clears held and fires nothing.
  - A and Left share the left held flag; D and Right share the right held flag.
- sel_level toggles only on a fired sel make.
- Pulses are never merged. At most one action per byte, so actions cannot be simultaneous.
- frame_err does not clear ext, brk or held flags.
- Reset mid-frame: the FSM returns to IDLE immediately. The next byte must begin with a fresh start bit.

Decomposition:
- Shared package ps2_pkg holds:
  - scan-code constants: SC_EXT=E0, SC_BRK=F0, SC_A, SC_D, SC_LEFT, SC_RIGHT, SC_ENTER, SC_ESC, SC_SPACE
  - frame state enum
  - action index constants
- Sub-module ps2_rx: synchronizer, filter, frame FSM and timeout. Outputs scan_valid, scan_code, frame_err.
- ps2_keypad instantiates ps2_rx and contains the decoder and held flags.

Test Plan:
- Bench bit timing: ps2_clk period 60 µs for all scenarios.
- Frame 0x1C (parity bit 0, stop 1) -> scan_valid once, scan_code=0x1C, left_pulse exactly 1 cycle after scan_valid, no other pulse.
- Sequence E0 74, E0 74, E0 F0 74, E0 74 -> right_pulse fires on the 1st and 4th make only; sel_level stays 0.
- 29, F0 29, 29, F0 29 -> sel_level goes 0→1→0; no left, right, start or reset pulses.
- Frame 0x5A with the parity bit flipped -> frame_err pulse, no scan_valid, no start_pulse. A following good 0x5A -> start_pulse.
- Send start + 3 data bits, then idle 3 ms -> frame_err at 2 ms. A following good 0x76 frame -> reset_pulse.
- ps2_clk glitches of 3 clk cycles low during idle -> no fall, no frame_err. Assert reset mid-frame -> all outputs 0; the next full frame 0x23 -> right_pulse.
